// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port line-burst memory arbiter.
//   DEF_ADDR_LEN      : memory word-address width
//   DEF_LINE_ADDR_LEN : log2 of words per line
//   state_e           : burst controller states
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_LEN      = 11;
   localparam int unsigned DEF_LINE_ADDR_LEN = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Bundle of the requester handshakes and the single-port memory bus.
//   req*/we*/laddr*/wline* : line requests from port 0 / port 1
//   done*/rline/busy       : completion pulses, shared read line, activity flag
//   mem_*                  : word memory access (1-cycle registered read)
// slave  : arbiter side; master : requesters + memory side.
interface mem_line_arbiter_if #(
   parameter int unsigned ADDR_LEN      = mem_arb_pkg::DEF_ADDR_LEN,
   parameter int unsigned LINE_ADDR_LEN = mem_arb_pkg::DEF_LINE_ADDR_LEN
);
   localparam int unsigned TAG_LEN    = ADDR_LEN - LINE_ADDR_LEN;
   localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;

   logic                    req0, req1;
   logic                    we0, we1;
   logic [TAG_LEN-1:0]      laddr0, laddr1;
   logic [32*LINE_WORDS-1:0] wline0, wline1;
   logic                    done0, done1;
   logic [32*LINE_WORDS-1:0] rline;
   logic                    busy;
   logic [ADDR_LEN-1:0]     mem_addr;
   logic                    mem_wr_req;
   logic [31:0]             mem_wr_data;
   logic [31:0]             mem_rd_data;

   modport slave (
      input  req0, req1, we0, we1, laddr0, laddr1, wline0, wline1, mem_rd_data,
      output done0, done1, rline, busy, mem_addr, mem_wr_req, mem_wr_data
   );

   modport master (
      output req0, req1, we0, we1, laddr0, laddr1, wline0, wline1, mem_rd_data,
      input  done0, done1, rline, busy, mem_addr, mem_wr_req, mem_wr_data
   );

endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin two-port line-burst controller in front of a single-port word memory.
// Each granted request becomes LINE_WORDS back-to-back word reads or writes; the
// assembled read line is returned on the shared rline output.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester handshakes and memory bus (slave modport)
module mem_line_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_LEN      = DEF_ADDR_LEN,
   parameter int unsigned LINE_ADDR_LEN = DEF_LINE_ADDR_LEN
) (
   input  logic                clk,
   input  logic                rst,
   mem_line_arbiter_if.slave   bus
);

   localparam int unsigned TAG_LEN    = ADDR_LEN - LINE_ADDR_LEN;
   localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;
   localparam int unsigned CNT_W      = LINE_ADDR_LEN + 1;

   state_e                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          last_gnt_q, last_gnt_d;
   logic                          port_q, port_d;
   logic                          we_q, we_d;
   logic [TAG_LEN-1:0]            laddr_q, laddr_d;
   logic [LINE_WORDS-1:0][31:0]   wline_q, wline_d;
   logic [LINE_WORDS-1:0][31:0]   rline_q, rline_d;
   logic                          done0_q, done0_d;
   logic                          done1_q, done1_d;
   logic                          busy_q, busy_d;
   logic [ADDR_LEN-1:0]           mem_addr_q, mem_addr_d;
   logic                          mem_wr_req_q, mem_wr_req_d;
   logic [31:0]                   mem_wr_data_q, mem_wr_data_d;
   logic                          gnt;

   // Next-state logic; outputs are decoded from the next state so they are
   // registered yet line up with the state they belong to.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_gnt_d = last_gnt_q;
      port_d     = port_q;
      we_d       = we_q;
      laddr_d    = laddr_q;
      wline_d    = wline_q;
      rline_d    = rline_q;
      gnt        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // On a tie the port that did not win last time gets the grant.
               gnt        = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
               last_gnt_d = gnt;
               port_d     = gnt;
               we_d       = gnt ? bus.we1    : bus.we0;
               laddr_d    = gnt ? bus.laddr1 : bus.laddr0;
               wline_d    = gnt ? bus.wline1 : bus.wline0;
               cnt_d      = '0;
               state_d    = we_d ? WR : RD;
            end
         end
         RD: begin
            // Read data lags the address by one cycle.
            if (cnt_q != '0)
               rline_d[LINE_ADDR_LEN'(cnt_q - CNT_W'(1))] = bus.mem_rd_data;
            if (cnt_q == CNT_W'(LINE_WORDS)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WR: begin
            if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d        = (state_d != IDLE);
      done0_d       = (state_d == DONE) && !port_d;
      done1_d       = (state_d == DONE) &&  port_d;
      mem_wr_req_d  = (state_d == WR);
      mem_addr_d    = '0;
      mem_wr_data_d = '0;
      // The extra RD cycle (counter top bit set) only collects the last word.
      if ((state_d == WR) || ((state_d == RD) && !cnt_d[LINE_ADDR_LEN]))
         mem_addr_d = {laddr_d, cnt_d[LINE_ADDR_LEN-1:0]};
      if (state_d == WR)
         mem_wr_data_d = wline_d[cnt_d[LINE_ADDR_LEN-1:0]];
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         last_gnt_q    <= 1'b1;
         port_q        <= 1'b0;
         we_q          <= 1'b0;
         laddr_q       <= '0;
         wline_q       <= '0;
         rline_q       <= '0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         busy_q        <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_req_q  <= 1'b0;
         mem_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_gnt_q    <= last_gnt_d;
         port_q        <= port_d;
         we_q          <= we_d;
         laddr_q       <= laddr_d;
         wline_q       <= wline_d;
         rline_q       <= rline_d;
         done0_q       <= done0_d;
         done1_q       <= done1_d;
         busy_q        <= busy_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_req_q  <= mem_wr_req_d;
         mem_wr_data_q <= mem_wr_data_d;
      end
   end

   assign bus.done0       = done0_q;
   assign bus.done1       = done1_q;
   assign bus.rline       = rline_q;
   assign bus.busy        = busy_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wr_req  = mem_wr_req_q;
   assign bus.mem_wr_data = mem_wr_data_q;

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Two-requester line-burst controller for the single-port word memory (ADDR_LEN-bit word address, 1-cycle registered read, write on posedge when write request high). It sits between the I-side and D-side cache miss handlers and the memory. It grants one requester at a time in round-robin order and sequences each line read or line write as back-to-back single-word memory accesses. It then returns the assembled line.

## Interface
- ADDR_LEN, 11: memory word-address width.
- LINE_ADDR_LEN, 3: log2 words per line; LINE_WORDS = 1<<LINE_ADDR_LEN.
- TAG_LEN (derived), ADDR_LEN-LINE_ADDR_LEN: line-address width.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  line request from port 0 / port 1; held high until the matching done pulse.
- we0, we1  in  1  1 = line write, 0 = line read; stable while req high.
- laddr0, laddr1  in  TAG_LEN  line address; stable while req high.
- wline0, wline1  in  32*LINE_WORDS  write line, word i at bits [32i+31:32i]; stable while req high.
- done0, done1  out  1  one-cycle completion pulse per port.
- rline  out  32*LINE_WORDS  last read line, shared by both ports; valid from done onward until the next read completes.
- busy  out  1  state != IDLE.
- mem_addr  out  ADDR_LEN  {latched line address, word index}; 0 in IDLE.
- mem_wr_req  out  1  memory write strobe.
- mem_wr_data  out  32  word being written.
- mem_rd_data  in  32  memory read data; word for the address presented in the previous cycle.

## Operation
- States: IDLE, RD, WR, DONE. Word counter cnt is LINE_ADDR_LEN+1 bits wide.
- IDLE:
  - Any req high: choose the winner, latch port id, we, laddr and wline, clear cnt.
  - Next state is WR if we=1, else RD.
- Arbitration:
  - Single request is granted directly.
  - With both requests high, grant the port that is not last_gnt; last_gnt is updated on every grant.
  - last_gnt resets to 1, so port 0 wins the first tie.
- RD: lasts LINE_WORDS+1 cycles, cnt = 0..LINE_WORDS.
  - While cnt < LINE_WORDS: mem_addr = {laddr, cnt[LINE_ADDR_LEN-1:0]}.
  - While cnt >= 1: capture mem_rd_data into rline word cnt-1.
  - At cnt = LINE_WORDS: go to DONE.
- WR: lasts LINE_WORDS cycles.
  - mem_wr_req = 1, mem_addr = {laddr, cnt}, mem_wr_data = latched wline word cnt.
  - After word LINE_WORDS-1: go to DONE.
- DONE: assert done of the granted port for exactly one cycle, then go to IDLE.
- Requester rule: req is cleared on the same edge at which the requester samples done=1, so req is already low in the following IDLE cycle. A new request may be raised in that IDLE cycle.
- Requests arriving while busy wait; no preemption.
- Latched we/laddr/wline are used for the whole burst; requester changes after grant are ignored.
- rline is written only during RD; a write leaves it unchanged.

## Timing
- Read: req seen in IDLE at cycle 0 (grant edge); RD occupies cycles 1..LINE_WORDS+1; done in cycle LINE_WORDS+2 (10 for default).
- Write: WR occupies cycles 1..LINE_WORDS; done in cycle LINE_WORDS+1 (9 for default).
- Back-to-back requests: one IDLE cycle between the DONE of one transfer and the first access of the next.
- Reset (any time, including mid-burst):
  - State goes to IDLE, cnt=0, last_gnt=1.
  - done0=done1=0, busy=0, rline=0, mem_addr=0, mem_wr_req=0, mem_wr_data=0.
  - Words already written by an aborted write stay in memory; no done is issued for the aborted transfer.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, RD, WR, DONE}.
  - Default ADDR_LEN/LINE_ADDR_LEN localparams.
- Single module, no sub-module: the arbiter is a 1-bit last_gnt compare. The memory is instantiated beside this block by the integrating level, not inside it.

## Test plan
- Port 0 reads line 5 after memory is preloaded with word i = 0x1000+i (addresses 40..47) -> done0 in cycle 10 after grant; rline words = 0x1028..0x102F; done1 stays 0.
- Port 1 writes line 2 with word i = 0xA0+i, then port 0 reads line 2 -> 8 consecutive mem_wr_req cycles at addresses 16..23; done1 after 9 cycles; the following read returns 0xA0..0xA7.
- req0 and req1 raised in the same cycle, both held and re-raised repeatedly -> grants alternate 0,1,0,1; first grant goes to port 0.
- req1 raised mid-burst of port 0 -> port 1 is granted only in the IDLE after done0; the port-0 burst is unaffected.
- rst asserted on the 4th WR cycle -> all outputs 0 immediately (asynchronous); words 0..2 written, word 3 not; no done; the next read of the same line returns the partially written data.
- laddr0 and wline0 changed after the grant cycle -> memory receives the originally latched address and data.
